fht_addr_gen: RTL and testbench
===============================

Name: fht_addr_gen

Overview:
- Stage sequencer that drives the 2-point FHT butterfly (fht_but) in-place over an N-point ping-pong RAM pair.
- Per FHT stage it issues the three operand read addresses and the twiddle ROM address, then the two result write addresses and strobes, delayed to match butterfly latency.
- Sits between the top-level FHT controller (start/done) and the data RAMs, twiddle ROM and butterfly.
- Input bit-reversal is handled elsewhere (loader).

Parameters:
- A_BIT, 8: log2(N); N = 2^A_BIT points, A_BIT stages.
- LAT, 3: cycles from x1/x2 read issue to matching butterfly result valid at RAM write port. Minimum 2.

Ports:
- iCLK  in  1  clock.
- iRESET  in  1  reset, asynchronous, active-low.
- iSTART  in  1  start transform; sampled only in IDLE.
- oRDY  out  1  high in IDLE.
- oDONE  out  1  one-cycle pulse after the last write of the last stage.
- oSTAGE  out  ceil(log2(A_BIT))  current stage s.
- oBANK  out  1  read bank = s[0]; writes go to ~oBANK.
- oRD_EN  out  1  x1/x2 read strobe.
- oRD_ADDR_1  out  A_BIT  x1 address.
- oRD_ADDR_2  out  A_BIT  x2 address.
- oROM_ADDR  out  A_BIT-1  twiddle (sin/cos) ROM address.
- oRD_EN_0  out  1  x0 read strobe.
- oRD_ADDR_0  out  A_BIT  x0 address.
- oWR_EN  out  1  y0/y1 write strobe.
- oWR_ADDR_0  out  A_BIT  y0 address.
- oWR_ADDR_1  out  A_BIT  y1 address.

Behaviour:
- All outputs registered except oRDY, which is decoded from state.
- Reset (async, any time, including mid-transform): state IDLE; all counters, addresses, enables, oDONE, oSTAGE and oBANK = 0; the delay pipeline is cleared. oRDY = 1 while in IDLE after reset.
- FSM states and transitions:
  - IDLE -> RUN on iSTART = 1. iSTART is ignored in all other states.
  - RUN -> FLUSH after N/2 read cycles.
  - FLUSH -> RUN (next stage) after LAT cycles.
  - FLUSH -> IDLE after LAT cycles of the last stage; oDONE pulses on the cycle of entering IDLE.
- Stage s = 0..A_BIT-1; half = 2^s. Butterfly counter b = 0..N/2-1. g = b>>s, k = b&(half-1), base = g<<(s+1).
- Read addresses:
  - rd1 = base+half+k.
  - rd2 = base+half+((half-k)&(half-1)).
  - rd0 = base+k.
  - rom = k<<(A_BIT-1-s).
- Timing:
  - oRD_EN, rd1, rd2 and rom are issued together, one b per cycle.
  - oRD_EN_0 and rd0 are the same b delayed one cycle, because x0 enters the butterfly one cycle after x1, x2, sin and cos.
  - oWR_EN, wr0 = base+k and wr1 = base+half+k are the oRD_EN-cycle values delayed exactly LAT cycles through a shift register.
- Stage timing: with iSTART sampled at cycle T:
  - First oRD_EN is at T+1.
  - Stage s reads at T+1+s(N/2+LAT) through T+s(N/2+LAT)+N/2.
  - Stage s+1's first read immediately follows stage s's last write (no RAW hazard across banks).
  - oSTAGE/oBANK increment on the first read cycle of the new stage.
- oDONE at T+1+A_BIT(N/2+LAT). oRDY is 1 in the same cycle.
- Stage 0: rd1 = rd2 and rom = 0 (cos = max, sin = 0).
- Address arithmetic is unsigned, A_BIT wide; no wrap-around occurs in legal ranges.

Test Plan:
- Reset mid-RUN (A_BIT=3, LAT=3, drop iRESET at T+5) -> all outputs 0 asynchronously, oRDY=1; a new iSTART restarts from stage 0, b=0.
- Full run, A_BIT=3, LAT=3, iSTART at T -> oRD_EN high T+1..T+4, T+8..T+11 and T+15..T+18; oWR_EN high T+4..T+7, T+11..T+14 and T+18..T+21; oDONE only at T+22; oBANK sequence 0, 1, 0.
- Stage 2 address check (A_BIT=3) -> (rd0, rd1, rd2, rom) = (0,4,4,0), (1,5,7,1), (2,6,6,2), (3,7,5,3). rd0 lags one cycle; wr0/wr1 equal rd0/rd1 delayed LAT.
- Stage 1 address check (A_BIT=3), b=3 -> rd0=5, rd1=7, rd2=7, rom=2. b=1 -> rd0=1, rd1=3, rd2=3, rom=2.
- iSTART held high throughout and re-pulsed mid-run -> no restart; exactly one oDONE per transform; a second transform begins the cycle after oDONE if iSTART is still high.
- End-to-end with fht_but and RAM/ROM models, A_BIT=8, impulse input -> every output bin = 2^15/256 within ±1 LSB.

Source files
------------

// File: rtl/fht_addr_gen_if.sv
// rtl/fht_addr_gen_if.sv - controller, RAM, ROM and butterfly side bus of the FHT stage sequencer
interface fht_addr_gen_if #(
    parameter int A_BIT = 8
);
    localparam int SW = (A_BIT > 1) ? $clog2(A_BIT) : 1;

    logic             iSTART;
    logic             oRDY;
    logic             oDONE;
    logic [SW-1:0]    oSTAGE;
    logic             oBANK;
    logic             oRD_EN;
    logic [A_BIT-1:0] oRD_ADDR_1;
    logic [A_BIT-1:0] oRD_ADDR_2;
    logic [A_BIT-2:0] oROM_ADDR;
    logic             oRD_EN_0;
    logic [A_BIT-1:0] oRD_ADDR_0;
    logic             oWR_EN;
    logic [A_BIT-1:0] oWR_ADDR_0;
    logic [A_BIT-1:0] oWR_ADDR_1;

    // Controller side: requests a transform and observes the sequencer.
    modport master (
        output iSTART,
        input  oRDY, oDONE, oSTAGE, oBANK,
        input  oRD_EN, oRD_ADDR_1, oRD_ADDR_2, oROM_ADDR,
        input  oRD_EN_0, oRD_ADDR_0,
        input  oWR_EN, oWR_ADDR_0, oWR_ADDR_1
    );

    // Sequencer side.
    modport slave (
        input  iSTART,
        output oRDY, oDONE, oSTAGE, oBANK,
        output oRD_EN, oRD_ADDR_1, oRD_ADDR_2, oROM_ADDR,
        output oRD_EN_0, oRD_ADDR_0,
        output oWR_EN, oWR_ADDR_0, oWR_ADDR_1
    );
endinterface

// File: rtl/fht_addr_gen.sv
// rtl/fht_addr_gen.sv - in-place FHT stage sequencer producing butterfly read/write addresses
module fht_addr_gen #(
    parameter int A_BIT = 8,
    parameter int LAT   = 3
) (
    input  logic           iCLK,
    input  logic           iRESET,
    fht_addr_gen_if.slave  bus
);
    localparam int SW = (A_BIT > 1) ? $clog2(A_BIT) : 1;
    localparam int BW = A_BIT - 1;
    localparam int RW = A_BIT - 1;
    localparam int CW = $clog2(LAT + 1);

    localparam logic [BW-1:0]    B_LAST = {BW{1'b1}};
    localparam logic [SW-1:0]    S_LAST = SW'(A_BIT - 1);
    localparam logic [CW-1:0]    C_RUN  = CW'(LAT - 1);
    localparam logic [CW-1:0]    C_END  = CW'(LAT);
    localparam logic [A_BIT-1:0] ONE    = A_BIT'(1);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t           state;
    logic [SW-1:0]    s;
    logic [BW-1:0]    b;
    logic [CW-1:0]    cnt;
    logic             issue;

    logic [A_BIT-1:0] half;
    logic [A_BIT-1:0] k;
    logic [A_BIT-1:0] base;
    logic [A_BIT-1:0] a_rd0;
    logic [A_BIT-1:0] a_rd1;
    logic [A_BIT-1:0] a_rd2;
    logic [RW-1:0]    a_rom;

    logic             rd_en;
    logic [A_BIT-1:0] rd_addr_1;
    logic [A_BIT-1:0] rd_addr_2;
    logic [RW-1:0]    rom_addr;
    logic [A_BIT-1:0] wr0_iss;
    logic [SW-1:0]    stage;
    logic             bank;
    logic             done;

    logic             rd_en_0;
    logic [A_BIT-1:0] rd_addr_0;
    logic [LAT-1:0]   wr_en_pipe;
    logic [A_BIT-1:0] wr0_pipe [LAT];
    logic [A_BIT-1:0] wr1_pipe [LAT];

    // A butterfly is issued on every RUN cycle and on the IDLE cycle that accepts a start.
    assign issue = (state == RUN) || ((state == IDLE) && bus.iSTART);

    // Butterfly operand addresses for the current stage s and butterfly index b.
    always_comb begin
        half  = ONE << s;
        k     = A_BIT'(b) & (half - ONE);
        base  = ((A_BIT'(b) >> s) << s) << 1;
        a_rd0 = base + k;
        a_rd1 = base + half + k;
        a_rd2 = base + half + ((half - k) & (half - ONE));
        a_rom = RW'(k << (S_LAST - s));
    end

    // Stage sequencing: N/2 issue cycles per stage, then LAT cycles for the writes to drain.
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            state     <= IDLE;
            s         <= '0;
            b         <= '0;
            cnt       <= '0;
            rd_en     <= 1'b0;
            rd_addr_1 <= '0;
            rd_addr_2 <= '0;
            rom_addr  <= '0;
            wr0_iss   <= '0;
            stage     <= '0;
            bank      <= 1'b0;
            done      <= 1'b0;
        end else begin
            rd_en <= 1'b0;
            done  <= 1'b0;
            if (issue) begin
                rd_en     <= 1'b1;
                rd_addr_1 <= a_rd1;
                rd_addr_2 <= a_rd2;
                rom_addr  <= a_rom;
                wr0_iss   <= a_rd0;
                stage     <= s;
                bank      <= s[0];
                b         <= b + BW'(1);
                if (b == B_LAST) begin
                    state <= FLUSH;
                    cnt   <= '0;
                end else begin
                    state <= RUN;
                end
            end else if (state == FLUSH) begin
                cnt <= cnt + CW'(1);
                if (s == S_LAST) begin
                    // One extra cycle so done lands just after the final write.
                    if (cnt == C_END) begin
                        state <= IDLE;
                        s     <= '0;
                        done  <= 1'b1;
                    end
                end else if (cnt == C_RUN) begin
                    state <= RUN;
                    s     <= s + SW'(1);
                end
            end
        end
    end

    // x0 trails x1/x2 by one cycle; write strobe and addresses trail the read issue by LAT.
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            rd_en_0    <= 1'b0;
            rd_addr_0  <= '0;
            wr_en_pipe <= '0;
            for (int i = 0; i < LAT; i++) begin
                wr0_pipe[i] <= '0;
                wr1_pipe[i] <= '0;
            end
        end else begin
            rd_en_0     <= rd_en;
            rd_addr_0   <= wr0_iss;
            wr_en_pipe  <= {wr_en_pipe[LAT-2:0], rd_en};
            wr0_pipe[0] <= wr0_iss;
            wr1_pipe[0] <= rd_addr_1;
            for (int i = 1; i < LAT; i++) begin
                wr0_pipe[i] <= wr0_pipe[i-1];
                wr1_pipe[i] <= wr1_pipe[i-1];
            end
        end
    end

    assign bus.oRDY       = (state == IDLE);
    assign bus.oDONE      = done;
    assign bus.oSTAGE     = stage;
    assign bus.oBANK      = bank;
    assign bus.oRD_EN     = rd_en;
    assign bus.oRD_ADDR_1 = rd_addr_1;
    assign bus.oRD_ADDR_2 = rd_addr_2;
    assign bus.oROM_ADDR  = rom_addr;
    assign bus.oRD_EN_0   = rd_en_0;
    assign bus.oRD_ADDR_0 = rd_addr_0;
    assign bus.oWR_EN     = wr_en_pipe[LAT-1];
    assign bus.oWR_ADDR_0 = wr0_pipe[LAT-1];
    assign bus.oWR_ADDR_1 = wr1_pipe[LAT-1];
endmodule

// File: tb/tb_fht_addr_gen.sv
// tb/tb_fht_addr_gen.sv - scoreboard bench for the FHT stage sequencer
module tb_fht_addr_gen;
    localparam int A_BIT  = 3;
    localparam int LAT    = 3;
    localparam int N      = 1 << A_BIT;
    localparam int HALF_N = N / 2;
    localparam int SPAN   = HALF_N + LAT;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    fht_addr_gen_if #(.A_BIT(A_BIT)) bus ();

    fht_addr_gen #(.A_BIT(A_BIT), .LAT(LAT)) dut (
        .iCLK   (clk),
        .iRESET (rst_n),
        .bus    (bus)
    );

    typedef struct {
        int cyc;
        int s;
        int b;
        int v0;
        int v1;
        int v2;
    } ev_t;

    ev_t rd_q[$];
    ev_t rd0_q[$];
    ev_t wr_q[$];
    ev_t done_q[$];
    ev_t m_ev;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int idle_at  = 0;
    bit capture_on = 1'b0;

    int cap_rd0 [A_BIT][HALF_N];
    int cap_rd1 [A_BIT][HALF_N];
    int cap_rd2 [A_BIT][HALF_N];
    int cap_rom [A_BIT][HALF_N];

    int s2_rd0 [HALF_N] = '{0, 1, 2, 3};
    int s2_rd1 [HALF_N] = '{4, 5, 6, 7};
    int s2_rd2 [HALF_N] = '{4, 7, 6, 5};
    int s2_rom [HALF_N] = '{0, 1, 2, 3};

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected behaviour of one whole transform whose start is accepted by the edge that makes cyc == e.
    task automatic push_transform(input int e);
        ev_t ev;
        for (int s = 0; s < A_BIT; s++) begin
            for (int b = 0; b < HALF_N; b++) begin
                int half;
                int g;
                int k;
                int base;
                int t;
                half = 2 ** s;
                g    = b / half;
                k    = b % half;
                base = g * 2 * half;
                t    = e + s * SPAN + b;
                ev = '{t, s, b, base + half + k, base + half + ((half - k) % half), k * (2 ** (A_BIT - 1 - s))};
                rd_q.push_back(ev);
                ev = '{t + 1, s, b, base + k, 0, 0};
                rd0_q.push_back(ev);
                ev = '{t + LAT, s, b, base + k, base + half + k, 0};
                wr_q.push_back(ev);
            end
        end
        ev = '{e + A_BIT * SPAN, 0, 0, 0, 0, 0};
        done_q.push_back(ev);
        idle_at = e + A_BIT * SPAN;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rdy"},      bus.oRDY, 1);
        check({tag, "_done"},     bus.oDONE, 0);
        check({tag, "_stage"},    bus.oSTAGE, 0);
        check({tag, "_bank"},     bus.oBANK, 0);
        check({tag, "_rd_en"},    bus.oRD_EN, 0);
        check({tag, "_rd_addr1"}, bus.oRD_ADDR_1, 0);
        check({tag, "_rd_addr2"}, bus.oRD_ADDR_2, 0);
        check({tag, "_rom"},      bus.oROM_ADDR, 0);
        check({tag, "_rd_en0"},   bus.oRD_EN_0, 0);
        check({tag, "_rd_addr0"}, bus.oRD_ADDR_0, 0);
        check({tag, "_wr_en"},    bus.oWR_EN, 0);
        check({tag, "_wr_addr0"}, bus.oWR_ADDR_0, 0);
        check({tag, "_wr_addr1"}, bus.oWR_ADDR_1, 0);
    endtask

    // Reference model: accepts a start only when its own idea of the sequencer is idle.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rst_n && bus.iSTART && (cyc - 1 >= idle_at)) begin
            push_transform(cyc);
        end
    end

    // Monitor: compare every presented strobe against the head of its expectation queue.
    always @(negedge clk) begin
        if (rst_n) begin
            check("rdy", bus.oRDY, (cyc >= idle_at) ? 1 : 0);
            if (bus.oRD_EN) begin
                if (rd_q.size() == 0) begin
                    check("rd_unexpected", 1, 0);
                end else begin
                    m_ev = rd_q.pop_front();
                    check("rd_cycle", cyc, m_ev.cyc);
                    check("rd_addr_1", bus.oRD_ADDR_1, m_ev.v0);
                    check("rd_addr_2", bus.oRD_ADDR_2, m_ev.v1);
                    check("rom_addr", bus.oROM_ADDR, m_ev.v2);
                    check("stage", bus.oSTAGE, m_ev.s);
                    check("bank", bus.oBANK, m_ev.s % 2);
                    if (capture_on) begin
                        cap_rd1[m_ev.s][m_ev.b] = bus.oRD_ADDR_1;
                        cap_rd2[m_ev.s][m_ev.b] = bus.oRD_ADDR_2;
                        cap_rom[m_ev.s][m_ev.b] = bus.oROM_ADDR;
                    end
                end
            end
            if (bus.oRD_EN_0) begin
                if (rd0_q.size() == 0) begin
                    check("rd0_unexpected", 1, 0);
                end else begin
                    m_ev = rd0_q.pop_front();
                    check("rd0_cycle", cyc, m_ev.cyc);
                    check("rd_addr_0", bus.oRD_ADDR_0, m_ev.v0);
                    if (capture_on) cap_rd0[m_ev.s][m_ev.b] = bus.oRD_ADDR_0;
                end
            end
            if (bus.oWR_EN) begin
                if (wr_q.size() == 0) begin
                    check("wr_unexpected", 1, 0);
                end else begin
                    m_ev = wr_q.pop_front();
                    check("wr_cycle", cyc, m_ev.cyc);
                    check("wr_addr_0", bus.oWR_ADDR_0, m_ev.v0);
                    check("wr_addr_1", bus.oWR_ADDR_1, m_ev.v1);
                end
            end
            if (bus.oDONE) begin
                if (done_q.size() == 0) begin
                    check("done_unexpected", 1, 0);
                end else begin
                    m_ev = done_q.pop_front();
                    check("done_cycle", cyc, m_ev.cyc);
                end
            end
        end
    end

    initial begin
        int e;
        for (int s = 0; s < A_BIT; s++) begin
            for (int b = 0; b < HALF_N; b++) begin
                cap_rd0[s][b] = -1;
                cap_rd1[s][b] = -1;
                cap_rd2[s][b] = -1;
                cap_rom[s][b] = -1;
            end
        end

        bus.iSTART = 1'b0;
        rst_n      = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check_all_zero("por");
        @(negedge clk);
        #1 rst_n = 1'b1;

        // Start, then pull reset asynchronously partway through the transform.
        repeat (2) @(negedge clk);
        #1 bus.iSTART = 1'b1;
        @(posedge clk);
        #1;
        e = cyc;
        bus.iSTART = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        rd_q.delete();
        rd0_q.delete();
        wr_q.delete();
        done_q.delete();
        idle_at = 0;
        #1;
        check_all_zero("mid_reset");
        check("mid_reset_at", cyc, e + 4);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;

        // Single clean transform with address capture for the fixed address tables.
        @(negedge clk);
        #1 capture_on = 1'b1;
        bus.iSTART = 1'b1;
        @(negedge clk);
        #1 bus.iSTART = 1'b0;
        repeat (A_BIT * SPAN + 4) @(negedge clk);
        #1 capture_on = 1'b0;

        for (int b = 0; b < HALF_N; b++) begin
            check("s2_rd0", cap_rd0[2][b], s2_rd0[b]);
            check("s2_rd1", cap_rd1[2][b], s2_rd1[b]);
            check("s2_rd2", cap_rd2[2][b], s2_rd2[b]);
            check("s2_rom", cap_rom[2][b], s2_rom[b]);
        end
        check("s1b3_rd0", cap_rd0[1][3], 5);
        check("s1b3_rd1", cap_rd1[1][3], 7);
        check("s1b3_rd2", cap_rd2[1][3], 7);
        check("s1b3_rom", cap_rom[1][3], 2);
        check("s1b1_rd0", cap_rd0[1][1], 1);
        check("s1b1_rd1", cap_rd1[1][1], 3);
        check("s1b1_rd2", cap_rd2[1][1], 3);
        check("s1b1_rom", cap_rom[1][1], 2);

        // Start held high: back-to-back transforms, no restarts mid-run.
        bus.iSTART = 1'b1;
        repeat (2 * (A_BIT * SPAN + 1) + 3) @(negedge clk);
        #1 bus.iSTART = 1'b0;

        // Random start pulses, many landing mid-transform.
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            #1 bus.iSTART = ($urandom_range(0, 5) == 0);
        end
        bus.iSTART = 1'b0;

        repeat (A_BIT * SPAN + 10) @(negedge clk);
        #1;
        check("rd_q_empty", rd_q.size(), 0);
        check("rd0_q_empty", rd0_q.size(), 0);
        check("wr_q_empty", wr_q.size(), 0);
        check("done_q_empty", done_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
